sensor_frame_packer: RTL and testbench

//  Transmit side of the 256-bit raw-sensor frame consumed by the fusion core's preprocessor/fault monitor.

---
 rtl/fusion_pkg.sv | 16 +
 rtl/frame_checksum_acc.sv | 26 ++
 rtl/sensor_frame_packer.sv | 119 +++++++++++
 tb/tb_sensor_frame_packer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
// fusion_pkg: shared frame geometry and checksum step for the sensor frame packers.
package fusion_pkg;
    localparam int DATA_WIDTH     = 16;
    localparam int NUM_WORDS      = 15;
    localparam int CHECKSUM_WIDTH = 16;
    localparam int COUNT_WIDTH    = 16;
    localparam int FRAME_WIDTH    = DATA_WIDTH * NUM_WORDS + CHECKSUM_WIDTH;

    function automatic logic [CHECKSUM_WIDTH-1:0] frame_checksum(
        input logic [CHECKSUM_WIDTH-1:0] acc,
        input logic [CHECKSUM_WIDTH-1:0] data,
        input logic                      corrupt
    );
        return (acc + data) ^ {CHECKSUM_WIDTH{corrupt}};
    endfunction
endpackage

// File: rtl/frame_checksum_acc.sv
// frame_checksum_acc: running modular sum of accepted samples, cleared when a frame closes.
module frame_checksum_acc
    import fusion_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      add_i,
    input  logic                      close_i,
    input  logic                      corrupt_i,
    input  logic [CHECKSUM_WIDTH-1:0] data_i,
    output logic [CHECKSUM_WIDTH-1:0] cks_o
);
    logic [CHECKSUM_WIDTH-1:0] acc_q, acc_d;

    // cks_o already includes the sample presented this cycle, so the closing word counts
    assign cks_o = frame_checksum(acc_q, data_i, corrupt_i);

    always_comb begin
        acc_d = close_i ? '0 : add_i ? acc_q + data_i : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
endmodule

// File: rtl/sensor_frame_packer.sv
// sensor_frame_packer: packs 16-bit samples into checksummed 256-bit frames,
// with an assembly slot that parks a closed frame while the output slot is busy.
module sensor_frame_packer #(
    parameter  int DATA_WIDTH     = fusion_pkg::DATA_WIDTH,
    parameter  int NUM_WORDS      = fusion_pkg::NUM_WORDS,
    parameter  int CHECKSUM_WIDTH = fusion_pkg::CHECKSUM_WIDTH,
    parameter  int COUNT_WIDTH    = fusion_pkg::COUNT_WIDTH,
    localparam int FRAME_WIDTH    = DATA_WIDTH * NUM_WORDS + CHECKSUM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_last,
    input  logic                   corrupt_cks,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [FRAME_WIDTH-1:0] frame_data,
    output logic                   frame_short,
    output logic [COUNT_WIDTH-1:0] frame_count
);
    localparam int BODY_WIDTH = DATA_WIDTH * NUM_WORDS;
    localparam int WCW        = $clog2(NUM_WORDS);

    logic [WCW-1:0]            wcnt_q, wcnt_d;
    logic [BODY_WIDTH-1:0]     asm_q, asm_d, word_ins;
    logic [CHECKSUM_WIDTH-1:0] asm_cks_q, asm_cks_d, cks;
    logic                      asm_short_q, asm_short_d, asm_full_q, asm_full_d;
    logic [FRAME_WIDTH-1:0]    out_q, out_d;
    logic                      out_short_q, out_short_d, out_full_q, out_full_d;
    logic [COUNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                      accept, last_word, close, drain, out_free;

    assign accept    = s_valid && !asm_full_q;
    assign last_word = wcnt_q == WCW'(NUM_WORDS - 1);
    assign close     = accept && (last_word || s_last);
    assign drain     = out_full_q && frame_ready;
    assign out_free  = !out_full_q || drain;
    // unwritten slots are always zero, so OR-ing places the word at its index
    assign word_ins  = {{(BODY_WIDTH - DATA_WIDTH){1'b0}}, s_data} << (32'(wcnt_q) * DATA_WIDTH);

    frame_checksum_acc u_cks (
        .clk       (clk),
        .rst_n     (rst_n),
        .add_i     (accept),
        .close_i   (close),
        .corrupt_i (corrupt_cks),
        .data_i    (CHECKSUM_WIDTH'(s_data)),
        .cks_o     (cks)
    );

    always_comb begin
        wcnt_d      = wcnt_q;
        asm_d       = asm_q;
        asm_cks_d   = asm_cks_q;
        asm_short_d = asm_short_q;
        asm_full_d  = asm_full_q;
        out_d       = out_q;
        out_short_d = out_short_q;
        out_full_d  = out_full_q && !frame_ready;
        cnt_d       = cnt_q + COUNT_WIDTH'(drain);
        if (asm_full_q && out_free) begin
            out_d       = {asm_cks_q, asm_q};
            out_short_d = asm_short_q;
            out_full_d  = 1'b1;
            asm_d       = '0;
            asm_cks_d   = '0;
            asm_short_d = 1'b0;
            asm_full_d  = 1'b0;
        end else if (close) begin
            wcnt_d = '0;
            if (out_free) begin
                out_d       = {cks, asm_q | word_ins};
                out_short_d = !last_word;
                out_full_d  = 1'b1;
                asm_d       = '0;
            end else begin
                asm_d       = asm_q | word_ins;
                asm_cks_d   = cks;
                asm_short_d = !last_word;
                asm_full_d  = 1'b1;
            end
        end else if (accept) begin
            asm_d  = asm_q | word_ins;
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q      <= '0;
            asm_q       <= '0;
            asm_cks_q   <= '0;
            asm_short_q <= 1'b0;
            asm_full_q  <= 1'b0;
            out_q       <= '0;
            out_short_q <= 1'b0;
            out_full_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            asm_q       <= asm_d;
            asm_cks_q   <= asm_cks_d;
            asm_short_q <= asm_short_d;
            asm_full_q  <= asm_full_d;
            out_q       <= out_d;
            out_short_q <= out_short_d;
            out_full_q  <= out_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign s_ready     = !asm_full_q;
    assign frame_valid = out_full_q;
    assign frame_data  = out_q;
    assign frame_short = out_short_q;
    assign frame_count = cnt_q;
endmodule

// File: tb/tb_sensor_frame_packer.sv
// tb_sensor_frame_packer: table-driven frames plus park/release and mid-frame reset sequences,
// with expected frames queued at stimulus time and popped on each output handshake.
module tb_sensor_frame_packer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0, s_last = 1'b0, corrupt_cks = 1'b0, frame_ready = 1'b1;
    logic [15:0]  s_data = '0;
    logic         s_ready, frame_valid, frame_short;
    logic [255:0] frame_data;
    logic [15:0]  frame_count;

    sensor_frame_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .corrupt_cks (corrupt_cks),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_short (frame_short),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] start;
        logic [15:0] step;
        logic        last;
        logic        corrupt;
        logic [15:0] cks;
        logic        short_f;
    } vec_t;

    typedef struct {
        logic [255:0] data;
        logic         short_f;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cnt_m = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input vec_t v);
        exp_t e;
        e.data = '0;
        for (int i = 0; i < v.n; i++) e.data[i*16 +: 16] = v.start + 16'(i) * v.step;
        e.data[255:240] = v.cks;
        e.short_f = v.short_f;
        return e;
    endfunction

    // called at posedge+1; returns at posedge+1 after the sample is accepted
    task automatic put(input logic [15:0] d, input logic last, input logic cor);
        int g;
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        corrupt_cks = cor;
        g = 0;
        @(negedge clk);
        while (!s_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!s_ready) chk("s_ready_wait", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
        corrupt_cks = 1'b0;
    endtask

    task automatic send(input vec_t v, input bit push);
        for (int i = 0; i < v.n; i++) begin
            if (push && i == v.n - 1) sb.push_back(mk(v));
            put(v.start + 16'(i) * v.step, v.last && i == v.n - 1, v.corrupt && i == v.n - 1);
        end
    endtask

    task automatic drain_wait();
        int g;
        g = 0;
        while (sb.size() > 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("scoreboard_empty", 256'(sb.size()), 0);
    endtask

    logic [255:0] held;
    logic         held_s;
    logic         held_v = 1'b0;
    exp_t         got;

    always @(negedge clk) begin
        if (rst_n) begin
            if (held_v && frame_valid) begin
                chk("hold_data", frame_data, held);
                chk("hold_short", frame_short, held_s);
            end
            held_v = frame_valid && !frame_ready;
            held = frame_data;
            held_s = frame_short;
            if (frame_valid && frame_ready) begin
                if (sb.size() == 0) chk("unexpected_frame", frame_valid, 0);
                else begin
                    got = sb.pop_front();
                    chk("frame_data", frame_data, got.data);
                    chk("frame_short", frame_short, got.short_f);
                    chk("frame_count", frame_count, 16'(cnt_m));
                    cnt_m++;
                end
            end
        end else held_v = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    vec_t vt[8];
    vec_t v2;
    vec_t part;
    int   c0;

    initial begin
        vt[0] = '{15, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0078, 1'b0};
        vt[1] = '{15, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'hFFF1, 1'b0};
        vt[2] = '{3,  16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0006, 1'b1};
        vt[3] = '{15, 16'h0001, 16'h0001, 1'b0, 1'b1, 16'hFF87, 1'b0};
        vt[4] = '{15, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0078, 1'b0};
        vt[5] = '{15, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0078, 1'b0};
        vt[6] = '{1,  16'hABCD, 16'h0000, 1'b1, 1'b0, 16'hABCD, 1'b1};
        vt[7] = '{14, 16'h1000, 16'h0100, 1'b1, 1'b0, 16'h3B00, 1'b1};
        v2    = '{15, 16'h0010, 16'h0001, 1'b0, 1'b0, 16'h0159, 1'b0};
        part  = '{7,  16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0};

        #12;
        chk("reset_in_valid", frame_valid, 0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_s_ready", s_ready, 1);
        chk("reset_frame_valid", frame_valid, 0);
        chk("reset_frame_data", frame_data, 0);
        chk("reset_frame_short", frame_short, 0);
        chk("reset_frame_count", frame_count, 0);

        foreach (vt[k]) begin
            send(vt[k], 1'b1);
            chk("latency_valid", frame_valid, 1);
        end
        drain_wait();
        chk("count_after_table", frame_count, 16'(cnt_m));

        // two frames with the sink stalled: second one parks
        frame_ready = 1'b0;
        send(vt[0], 1'b1);
        send(v2, 1'b1);
        chk("park_s_ready", s_ready, 0);
        chk("park_valid", frame_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("park_hold_s_ready", s_ready, 0);
        c0 = cnt_m;
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_s_ready", s_ready, 1);
        chk("release_valid", frame_valid, 1);
        chk("release_count1", frame_count, 16'(c0 + 1));
        @(posedge clk);
        #1;
        chk("release_valid_drop", frame_valid, 0);
        chk("release_count2", frame_count, 16'(c0 + 2));
        drain_wait();

        // reset in the middle of a frame discards it
        send(part, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset_s_ready", s_ready, 1);
        chk("midreset_valid", frame_valid, 0);
        chk("midreset_data", frame_data, 0);
        chk("midreset_short", frame_short, 0);
        chk("midreset_count", frame_count, 0);
        cnt_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(vt[0], 1'b1);
        chk("post_reset_latency", frame_valid, 1);
        drain_wait();
        chk("post_reset_count", frame_count, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
